// File: rtl/scaler_bank_v3_if.sv
// Snapshot read port of the scaler bank.
// Ports (signals):
//   scal_addr_i  ADDR_W  snapshot read address (driven by the register interface)
//   scal_rd_i    1       read strobe
//   scal_dat_o   WIDTH   snapshot count of the addressed channel
//   scal_ovf_o   1       overflow flag of the addressed channel
// Modports: master = register interface side, slave = scaler bank side.
interface scaler_bank_v3_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WIDTH  = 16
) ();

    logic [ADDR_W-1:0] scal_addr_i;
    logic              scal_rd_i;
    logic [WIDTH-1:0]  scal_dat_o;
    logic              scal_ovf_o;

    modport master (
        output scal_addr_i,
        output scal_rd_i,
        input  scal_dat_o,
        input  scal_ovf_o
    );

    modport slave (
        input  scal_addr_i,
        input  scal_rd_i,
        output scal_dat_o,
        output scal_ovf_o
    );

endinterface

// File: rtl/scaler_bank_v3.sv
// Trigger-scaler bank: counts rising edges on NCH asynchronous lines per gate
// period and publishes saturating counts plus sticky overflow flags into a
// snapshot bank read through a registered address/strobe port.
// Ports:
//   clk_i           system clock (clk33)
//   nrst_i          synchronous active-low reset
//   scal_i          NCH asynchronous scaler inputs
//   refpulse_i      asynchronous TURF reference pulse
//   gate_sel_i      gate source: 0 = internal timer, 1 = refpulse edge
//   mask_i          per-channel mask, 1 = channel held at 0
//   rd_bus          snapshot read port (address/strobe in, data/overflow out)
//   latch_o         one-cycle pulse when a new snapshot is published
//   refpulse_cnt_o  wrapping count of refpulse rising edges
//   period_cnt_o    wrapping count of published snapshots
module scaler_bank_v3 #(
    parameter int unsigned NCH           = 32,
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned PERIOD_CYCLES = 33000000
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic [NCH-1:0]        scal_i,
    input  logic                  refpulse_i,
    input  logic                  gate_sel_i,
    input  logic [NCH-1:0]        mask_i,
    scaler_bank_v3_if.slave       rd_bus,
    output logic                  latch_o,
    output logic [15:0]           refpulse_cnt_o,
    output logic [15:0]           period_cnt_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned TMR_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NCH-1:0]   scal_s0;
    logic [NCH-1:0]   scal_s1;
    logic [NCH-1:0]   scal_s2;
    logic [2:0]       ref_s;
    logic [NCH-1:0]   scal_edge_c;
    logic             ref_edge_c;

    logic             sel_q;
    logic             sel_chg_c;
    logic [TMR_W-1:0] timer_q;
    logic             gate_c;

    logic             count_en_c;
    logic             publish_c;

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [NCH-1:0]   ovf_q;
    logic [WIDTH-1:0] snap_dat_q [DEPTH];
    logic [DEPTH-1:0] snap_ovf_q;

    // Two-flop synchronisers followed by an edge register.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            scal_s0 <= '0;
            scal_s1 <= '0;
            scal_s2 <= '0;
            ref_s   <= '0;
        end else begin
            scal_s0 <= scal_i;
            scal_s1 <= scal_s0;
            scal_s2 <= scal_s1;
            ref_s   <= {ref_s[1:0], refpulse_i};
        end
    end

    assign scal_edge_c = scal_s1 & ~scal_s2;
    assign ref_edge_c  = ref_s[1] & ~ref_s[2];

    // A change of gate source restarts the timer and suppresses any gate that cycle.
    assign sel_chg_c = gate_sel_i ^ sel_q;

    // Gate timer and registered copy of the gate source.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            sel_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            sel_q <= gate_sel_i;
            if (sel_chg_c || (timer_q == TMR_LAST)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end
        end
    end

    assign gate_c = ~sel_chg_c & (sel_q ? ref_edge_c : (timer_q == TMR_LAST));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q <= ST_ALIGN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the first gate only aligns counting to a period boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ALIGN: if (gate_c) state_d = ST_COUNT;
            ST_COUNT: state_d = ST_COUNT;
            default:  state_d = ST_ALIGN;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        count_en_c = 1'b0;
        publish_c  = 1'b0;
        case (state_q)
            ST_COUNT: begin
                count_en_c = 1'b1;
                publish_c  = gate_c;
            end
            default: begin
                count_en_c = 1'b0;
                publish_c  = 1'b0;
            end
        endcase
    end

    // Per-channel saturating counters; a coincident edge on publish starts the new period at 1.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (mask_i[k] || !count_en_c) begin
                    cnt_q[k] <= '0;
                    ovf_q[k] <= 1'b0;
                end else if (publish_c) begin
                    cnt_q[k] <= WIDTH'(scal_edge_c[k]);
                    ovf_q[k] <= 1'b0;
                end else if (scal_edge_c[k]) begin
                    if (cnt_q[k] == CNT_MAX) begin
                        ovf_q[k] <= 1'b1;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + WIDTH'(1);
                    end
                end
            end
        end
    end

    // Snapshot bank sized to the full address space; entries at or above NCH stay 0,
    // so out-of-range reads return 0 without a separate compare.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                snap_dat_q[k] <= '0;
            end
            snap_ovf_q <= '0;
        end else if (publish_c) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                snap_dat_q[k] <= cnt_q[k];
                snap_ovf_q[k] <= ovf_q[k];
            end
        end
    end

    // Registered readout; data holds between strobes.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            rd_bus.scal_dat_o <= '0;
            rd_bus.scal_ovf_o <= 1'b0;
        end else if (rd_bus.scal_rd_i) begin
            rd_bus.scal_dat_o <= snap_dat_q[rd_bus.scal_addr_i];
            rd_bus.scal_ovf_o <= snap_ovf_q[rd_bus.scal_addr_i];
        end
    end

    // Publish strobe and status counters.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            latch_o        <= 1'b0;
            refpulse_cnt_o <= '0;
            period_cnt_o   <= '0;
        end else begin
            latch_o <= publish_c;
            if (ref_edge_c) begin
                refpulse_cnt_o <= refpulse_cnt_o + 16'd1;
            end
            if (publish_c) begin
                period_cnt_o <= period_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: doc/scaler_bank_v3.md
# scaler_bank_v3

Parametrised successor to the SURF trigger-scaler bank. Counts rising edges on `NCH` asynchronous trigger lines over a gate period, and publishes per-channel `WIDTH`-bit saturating counts plus overflow flags into a snapshot bank. The gate comes from an internal cycle timer or from the TURF reference pulse. The snapshot bank is read by the PLX register interface through a registered address/strobe port. Sits between the Level-1 trigger scaler outputs and the register interface in the clk33 domain.

## Interface
- `NCH`, 32: number of scaler channels (1..2^`ADDR_W`).
- `WIDTH`, 16: counter/snapshot width in bits (8..32).
- `ADDR_W`, 5: read address width.
- `PERIOD_CYCLES`, 33000000: internal gate period in clk_i cycles (≥4).
- `clk_i`  in  1  system clock (clk33). One clock; all logic on its rising edge.
- `nrst_i`  in  1  reset; synchronous, active-low.
- `scal_i`  in  `NCH`  scaler inputs, asynchronous to clk_i.
- `refpulse_i`  in  1  TURF reference pulse, asynchronous.
- `gate_sel_i`  in  1  gate source: 0 = internal timer, 1 = refpulse edge.
- `mask_i`  in  `NCH`  1 = channel does not count (counter held at 0).
- `scal_addr_i`  in  `ADDR_W`  snapshot read address.
- `scal_rd_i`  in  1  read strobe.
- `scal_dat_o`  out  `WIDTH`  snapshot count of addressed channel.
- `scal_ovf_o`  out  1  overflow flag of addressed channel.
- `latch_o`  out  1  one-cycle pulse: new snapshot published.
- `refpulse_cnt_o`  out  16  count of refpulse rising edges, wraps.
- `period_cnt_o`  out  16  count of published snapshots, wraps.

## Operation
- Input conditioning: each `scal_i` bit and `refpulse_i` pass through a 2-FF synchroniser and then an edge register. A rising edge is `s[1] & ~s[2]`. An input must be high ≥1 cycle and low ≥1 cycle between edges to be counted once.
- Gate event `gate`:
  - mode 0: timer counts 0..`PERIOD_CYCLES`-1 and asserts `gate` at the terminal count.
  - mode 1: `gate` asserts on the synchronised refpulse edge.
  - When `gate_sel_i` changes (registered compare), the timer clears to 0. No gate is generated by the switch itself.
- FSM:
  - ALIGN (reset state): counters held at 0; no snapshot. On the first `gate`, go to COUNT without publishing.
  - COUNT: per channel, an unmasked edge increments the counter. The counter saturates at 2^`WIDTH`-1, and a further edge at saturation sets the sticky channel `ovf`.
  - On `gate` in COUNT, the same edge does all of the following:
    - copies every counter and `ovf` into the snapshot bank;
    - clears `ovf`;
    - reloads each counter with 1 if an unmasked edge coincides, else 0;
    - increments `period_cnt_o`.
  - `latch_o` pulses the following cycle.
- Mask: asserting `mask_i[k]` clears counter k and `ovf[k]` on the next edge. Deasserting it resumes counting from 0.
- `refpulse_cnt_o` increments on every synchronised refpulse edge in every state and mode.
- Readout: when `scal_rd_i`=1 at an edge, `scal_dat_o`/`scal_ovf_o` load the snapshot at `scal_addr_i`, or 0/0 if address ≥ `NCH`. Outputs hold until the next read.
- Reset (`nrst_i`=0 at an edge):
  - FSM returns to ALIGN;
  - all counters, snapshot entries, `ovf`, timer, synchronisers and outputs are cleared;
  - this applies mid-period or mid-read;
  - reset dominates all other inputs.

## Timing
- Reset values: `scal_dat_o`=0, `scal_ovf_o`=0, `latch_o`=0, `refpulse_cnt_o`=0, `period_cnt_o`=0.
- `scal_i` edge to counter increment: counter updates at the 3rd rising clk edge after the input transition is sampled.
- Refpulse transition to `gate` (mode 1): 3 cycles. Snapshot is visible to a read strobe issued the cycle after `gate`.
- Read latency: 1 cycle from strobe to valid data.
- A read strobe in the same cycle as `gate` returns the previous snapshot.
- `latch_o` is high for exactly 1 cycle, 1 cycle after `gate`. Back-to-back gates (refpulse every 2 cycles) publish every gate.
- Mode-0 period is exactly `PERIOD_CYCLES` cycles between consecutive `latch_o` pulses.

## Test plan
- Reset, then mode 0 with `PERIOD_CYCLES`=100:
  - first `latch_o` occurs 200 cycles after reset release (ALIGN discards the first period);
  - then one every 100 cycles;
  - `period_cnt_o` = 1, 2, 3.
- Channel 3 toggled 10 times in one period (2 high / 2 low), channel 4 masked with the same stimulus:
  - read addr 3 → 10, ovf 0;
  - addr 4 → 0;
  - addr 40 (with `ADDR_W`=6) → 0.
- `WIDTH`=8, channel 0 given 300 edges in one period → snapshot 255, ovf 1. Next period with 5 edges → 5, ovf 0.
- Mode 1, refpulse edges 50 cycles apart, 7 pulses:
  - `refpulse_cnt_o` = 7;
  - 6 latch pulses (first gate only aligns);
  - an edge coincident with `gate` is counted in the new period (count 1).
- Read strobe asserted in the `gate` cycle returns the old snapshot; strobe one cycle later returns the new value.
- `nrst_i` low for 1 cycle mid-period with counters at 40:
  - all outputs are 0 the next cycle;
  - FSM is in ALIGN;
  - no `latch_o` until the second gate after release.
